decode_ctrl_stage: RTL and testbench

Registered, parametrised instruction-decode/control stage for the 5-stage RISC-V pipeline. It takes a raw 32-bit instruction from IF/ID, produces the full control bundle one cycle later through a valid/ready handshake, and adds features the combinational decoder lacks. Those features are RV32M decode with configurable multi-cycle MUL/DIV occupancy, illegal-instruction flagging, backpressure hold, and synchronous flush. It sits between the IF/ID register and the ID/EX register.

---
 rtl/decode_ctrl_stage.sv | 274 +++++++++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage: registered RV32I(+M) decode/control stage between IF/ID and ID/EX.
// Decodes a raw instruction into the control bundle and presents it one cycle after
// accept. MUL/DIV ops hold the stage for MUL_LAT/DIV_LAT cycles. Illegal encodings
// still flow through as single-cycle ops.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   flush               synchronous discard of the held or in-flight instruction
//   in_valid/in_ready   upstream handshake; instr is the raw instruction
//   out_valid/out_ready downstream handshake for the control bundle
//   aluop, rf_en, imm_en, jump_en, branch_en, mem_read, mem_write, sel_A,
//   mem_size, wb_sel, csr_rd, csr_wr, is_mret, illegal   registered control bundle
//   busy                high while a multi-cycle M op occupies the stage
module decode_ctrl_stage #(
    parameter bit          EN_M_EXT = 1'b1,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned DIV_LAT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  aluop,
    output logic        rf_en,
    output logic        imm_en,
    output logic        jump_en,
    output logic        branch_en,
    output logic        mem_read,
    output logic        mem_write,
    output logic        sel_A,
    output logic [2:0]  mem_size,
    output logic [1:0]  wb_sel,
    output logic        csr_rd,
    output logic        csr_wr,
    output logic        is_mret,
    output logic        illegal,
    output logic        busy
);
    localparam int unsigned MaxLat = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CntW   = (MaxLat > 1) ? $clog2(MaxLat) : 1;
    localparam logic [CntW-1:0] MulCnt = CntW'(MUL_LAT - 2);
    localparam logic [CntW-1:0] DivCnt = CntW'(DIV_LAT - 2);
    localparam bit MulMulti = (MUL_LAT > 1);
    localparam bit DivMulti = (DIV_LAT > 1);

    localparam logic [4:0] OpAdd = 5'b00000, OpSub = 5'b00001, OpSll = 5'b00010;
    localparam logic [4:0] OpSlt = 5'b00011, OpSltu = 5'b00100, OpXor = 5'b00101;
    localparam logic [4:0] OpSrl = 5'b00110, OpSra = 5'b00111, OpOr = 5'b01000;
    localparam logic [4:0] OpAnd = 5'b01001, OpMul = 5'b01011, OpLui = 5'b01100;
    localparam logic [4:0] OpAuipc = 5'b01101, OpMulh = 5'b10100, OpMulhsu = 5'b10101;
    localparam logic [4:0] OpMulhu = 5'b10110, OpDiv = 5'b10000, OpDivu = 5'b10001;
    localparam logic [4:0] OpRem = 5'b10010, OpRemu = 5'b10011;

    typedef struct packed {
        logic [4:0] aluop;
        logic       rf_en;
        logic       imm_en;
        logic       jump_en;
        logic       branch_en;
        logic       mem_read;
        logic       mem_write;
        logic       sel_a;
        logic [2:0] mem_size;
        logic [1:0] wb_sel;
        logic       csr_rd;
        logic       csr_wr;
        logic       is_mret;
        logic       illegal;
    } ctrl_t;

    typedef enum logic [1:0] {StEmpty, StFull, StWait} state_e;

    state_e          state;
    logic [CntW-1:0] cnt;
    ctrl_t           bundle;
    ctrl_t           dec;
    logic            is_m, is_div, bad;
    logic            accept, dec_multi;
    logic [CntW-1:0] dec_cnt;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    // Register and immediate fields are consumed downstream, not here.
    logic unused_fields;
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        dec    = '0;
        is_m   = 1'b0;
        is_div = 1'b0;
        bad    = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec.rf_en = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec.aluop = OpAdd;
                            3'b001:  dec.aluop = OpSll;
                            3'b010:  dec.aluop = OpSlt;
                            3'b011:  dec.aluop = OpSltu;
                            3'b100:  dec.aluop = OpXor;
                            3'b101:  dec.aluop = OpSrl;
                            3'b110:  dec.aluop = OpOr;
                            default: dec.aluop = OpAnd;
                        endcase
                    end
                    7'b0100000: begin
                        if (funct3 == 3'b000)      dec.aluop = OpSub;
                        else if (funct3 == 3'b101) dec.aluop = OpSra;
                        else                       bad = 1'b1;
                    end
                    7'b0000001: begin
                        if (EN_M_EXT) begin
                            is_m   = 1'b1;
                            is_div = funct3[2];
                            case (funct3)
                                3'b000:  dec.aluop = OpMul;
                                3'b001:  dec.aluop = OpMulh;
                                3'b010:  dec.aluop = OpMulhsu;
                                3'b011:  dec.aluop = OpMulhu;
                                3'b100:  dec.aluop = OpDiv;
                                3'b101:  dec.aluop = OpDivu;
                                3'b110:  dec.aluop = OpRem;
                                default: dec.aluop = OpRemu;
                            endcase
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.rf_en  = 1'b1;
                dec.imm_en = 1'b1;
                case (funct3)
                    3'b000: dec.aluop = OpAdd;
                    3'b001: begin
                        dec.aluop = OpSll;
                        bad       = (funct7 != 7'b0000000);
                    end
                    3'b010: dec.aluop = OpSlt;
                    3'b011: dec.aluop = OpSltu;
                    3'b100: dec.aluop = OpXor;
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec.aluop = OpSrl;
                        else if (funct7 == 7'b0100000) dec.aluop = OpSra;
                        else                           bad = 1'b1;
                    end
                    3'b110:  dec.aluop = OpOr;
                    default: dec.aluop = OpAnd;
                endcase
            end
            7'b0110111: begin
                dec.rf_en  = 1'b1;
                dec.imm_en = 1'b1;
                dec.aluop  = OpLui;
            end
            7'b0010111: begin
                dec.rf_en  = 1'b1;
                dec.imm_en = 1'b1;
                dec.sel_a  = 1'b1;
                dec.aluop  = OpAuipc;
            end
            7'b0000011: begin
                dec.rf_en    = 1'b1;
                dec.imm_en   = 1'b1;
                dec.mem_read = 1'b1;
                dec.mem_size = funct3;
                dec.wb_sel   = 2'b01;
            end
            7'b0100011: begin
                dec.imm_en    = 1'b1;
                dec.mem_write = 1'b1;
                dec.mem_size  = funct3;
            end
            7'b1100011: begin
                dec.imm_en    = 1'b1;
                dec.sel_a     = 1'b1;
                dec.branch_en = 1'b1;
            end
            7'b1101111: begin
                dec.rf_en   = 1'b1;
                dec.imm_en  = 1'b1;
                dec.jump_en = 1'b1;
                dec.sel_a   = 1'b1;
                dec.wb_sel  = 2'b10;
            end
            7'b1100111: begin
                dec.rf_en   = 1'b1;
                dec.imm_en  = 1'b1;
                dec.jump_en = 1'b1;
                dec.wb_sel  = 2'b10;
            end
            7'b1110011: begin
                dec.wb_sel = 2'b11;
                dec.rf_en  = (funct3 != 3'b000);
                case (funct3)
                    3'b000:  dec.is_mret = 1'b1;
                    3'b001:  dec.csr_wr  = 1'b1;
                    default: dec.csr_rd  = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        // Illegal ops travel as plain single-cycle bubbles carrying only the flag.
        if (bad) begin
            dec         = '0;
            dec.illegal = 1'b1;
            is_m        = 1'b0;
            is_div      = 1'b0;
        end
    end

    assign dec_multi = is_m & (is_div ? DivMulti : MulMulti);
    assign dec_cnt   = is_div ? DivCnt : MulCnt;

    assign in_ready  = (state == StEmpty) | ((state == StFull) & out_ready);
    assign accept    = in_valid & in_ready & ~flush;
    assign out_valid = (state == StFull);
    assign busy      = (state == StWait);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= StEmpty;
            cnt    <= '0;
            bundle <= '0;
        end else if (flush) begin
            state <= StEmpty;
            cnt   <= '0;
        end else if (accept) begin
            bundle <= dec;
            if (dec_multi) begin
                state <= StWait;
                cnt   <= dec_cnt;
            end else begin
                state <= StFull;
            end
        end else begin
            case (state)
                StFull: if (out_ready) state <= StEmpty;
                StWait: begin
                    if (cnt == '0) state <= StFull;
                    else           cnt   <= cnt - CntW'(1);
                end
                default: ;
            endcase
        end
    end

    assign aluop     = bundle.aluop;
    assign rf_en     = bundle.rf_en;
    assign imm_en    = bundle.imm_en;
    assign jump_en   = bundle.jump_en;
    assign branch_en = bundle.branch_en;
    assign mem_read  = bundle.mem_read;
    assign mem_write = bundle.mem_write;
    assign sel_A     = bundle.sel_a;
    assign mem_size  = bundle.mem_size;
    assign wb_sel    = bundle.wb_sel;
    assign csr_rd    = bundle.csr_rd;
    assign csr_wr    = bundle.csr_wr;
    assign is_mret   = bundle.is_mret;
    assign illegal   = bundle.illegal;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Self-checking bench for decode_ctrl_stage: table of single-cycle decodes plus
// directed sequences for M-op occupancy, backpressure, flush and async reset.
module tb_decode_ctrl_stage;
    localparam int unsigned MulLat = 3;
    localparam int unsigned DivLat = 8;

    localparam logic [31:0] IAdd  = 32'h002081B3;
    localparam logic [31:0] IMul  = 32'h022081B3;
    localparam logic [31:0] IDivu = 32'h0220D1B3;
    localparam logic [31:0] IDiv  = 32'h0220C1B3;
    localparam logic [31:0] ILw   = 32'h0000A183;
    localparam logic [31:0] ISw   = 32'h0030A023;
    localparam logic [31:0] IBeq  = 32'h00208063;

    // Expected bundle layout: {aluop, rf,imm,jump,branch,mr,mw,selA, mem_size, wb_sel,
    // csr_rd,csr_wr,is_mret,illegal}
    localparam logic [20:0] EAdd = {5'b00000, 7'b1000000, 3'b000, 2'b00, 4'b0000};
    localparam logic [20:0] ELw  = {5'b00000, 7'b1100100, 3'b010, 2'b01, 4'b0000};
    localparam logic [20:0] ESw  = {5'b00000, 7'b0100010, 3'b010, 2'b00, 4'b0000};
    localparam logic [20:0] EBeq = {5'b00000, 7'b0101001, 3'b000, 2'b00, 4'b0000};
    localparam logic [20:0] EIll = {5'b00000, 7'b0000000, 3'b000, 2'b00, 4'b0001};

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready, in_valid2;
    logic [31:0] instr;
    logic        in_ready, out_valid, busy;
    logic [4:0]  aluop;
    logic        rf_en, imm_en, jump_en, branch_en, mem_read, mem_write, sel_A;
    logic [2:0]  mem_size;
    logic [1:0]  wb_sel;
    logic        csr_rd, csr_wr, is_mret, illegal;
    logic        in_ready2, out_valid2, busy2;
    logic [4:0]  aluop2;
    logic        rf_en2, imm_en2, jump_en2, branch_en2, mem_read2, mem_write2, sel_A2;
    logic [2:0]  mem_size2;
    logic [1:0]  wb_sel2;
    logic        csr_rd2, csr_wr2, is_mret2, illegal2;
    logic [20:0] act, act2;

    int n_pass  = 0;
    int n_total = 0;
    int xfers   = 0;

    always #5 clk = ~clk;

    decode_ctrl_stage #(.EN_M_EXT(1'b1), .MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .out_valid(out_valid), .out_ready(out_ready), .aluop(aluop),
        .rf_en(rf_en), .imm_en(imm_en), .jump_en(jump_en), .branch_en(branch_en),
        .mem_read(mem_read), .mem_write(mem_write), .sel_A(sel_A), .mem_size(mem_size),
        .wb_sel(wb_sel), .csr_rd(csr_rd), .csr_wr(csr_wr), .is_mret(is_mret),
        .illegal(illegal), .busy(busy)
    );

    decode_ctrl_stage #(.EN_M_EXT(1'b0), .MUL_LAT(MulLat), .DIV_LAT(DivLat)) dut_nom (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid2), .in_ready(in_ready2),
        .instr(instr), .out_valid(out_valid2), .out_ready(1'b1), .aluop(aluop2),
        .rf_en(rf_en2), .imm_en(imm_en2), .jump_en(jump_en2), .branch_en(branch_en2),
        .mem_read(mem_read2), .mem_write(mem_write2), .sel_A(sel_A2),
        .mem_size(mem_size2), .wb_sel(wb_sel2), .csr_rd(csr_rd2), .csr_wr(csr_wr2),
        .is_mret(is_mret2), .illegal(illegal2), .busy(busy2)
    );

    assign act  = {aluop, rf_en, imm_en, jump_en, branch_en, mem_read, mem_write, sel_A,
                   mem_size, wb_sel, csr_rd, csr_wr, is_mret, illegal};
    assign act2 = {aluop2, rf_en2, imm_en2, jump_en2, branch_en2, mem_read2, mem_write2,
                   sel_A2, mem_size2, wb_sel2, csr_rd2, csr_wr2, is_mret2, illegal2};

    always @(posedge clk) if (!rst && out_valid && out_ready) xfers <= xfers + 1;

    typedef struct {
        logic [31:0] ins;
        logic [20:0] exp;
        string       name;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input string nm, input logic [31:0] i, input logic [4:0] a,
                       input logic [6:0] en, input logic [2:0] ms, input logic [1:0] wb,
                       input logic [3:0] cs);
        vec_t v;
        v.ins  = i;
        v.exp  = {a, en, ms, wb, cs};
        v.name = nm;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic run_m(input string nm, input logic [31:0] ins, input logic [4:0] exp_alu,
                         input int lat);
        @(negedge clk);
        instr     = ins;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            check($sformatf("%s_busy_c%0d", nm, k), 32'(busy), 32'(k < lat));
            check($sformatf("%s_ovalid_c%0d", nm, k), 32'(out_valid), 32'(k == lat));
            check($sformatf("%s_inrdy_c%0d", nm, k), 32'(in_ready), 32'(k == lat));
            if (k == 1) in_valid = 1'b0;
            if (k == lat) check({nm, "_aluop"}, 32'(aluop), 32'(exp_alu));
        end
        @(negedge clk);
        check({nm, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; instr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_bundle", 32'(act), 32'd0);
        check("rst_ovalid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_inrdy", 32'(in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_inrdy", 32'(in_ready), 32'd1);

        // en = {rf, imm, jump, branch, mem_read, mem_write, sel_A};
        // cs = {csr_rd, csr_wr, is_mret, illegal}
        add("add",        IAdd,         5'b00000, 7'b1000000, 3'b000, 2'b00, 4'b0000);
        add("sub",        32'h402081B3, 5'b00001, 7'b1000000, 3'b000, 2'b00, 4'b0000);
        add("sra",        32'h4020D1B3, 5'b00111, 7'b1000000, 3'b000, 2'b00, 4'b0000);
        add("sltu",       32'h0020B1B3, 5'b00100, 7'b1000000, 3'b000, 2'b00, 4'b0000);
        add("lw",         ILw,          5'b00000, 7'b1100100, 3'b010, 2'b01, 4'b0000);
        add("sw",         ISw,          5'b00000, 7'b0100010, 3'b010, 2'b00, 4'b0000);
        add("beq",        IBeq,         5'b00000, 7'b0101001, 3'b000, 2'b00, 4'b0000);
        add("lui",        32'h123451B7, 5'b01100, 7'b1100000, 3'b000, 2'b00, 4'b0000);
        add("auipc",      32'h00000197, 5'b01101, 7'b1100001, 3'b000, 2'b00, 4'b0000);
        add("jal",        32'h008000EF, 5'b00000, 7'b1110001, 3'b000, 2'b10, 4'b0000);
        add("jalr",       32'h000080E7, 5'b00000, 7'b1110000, 3'b000, 2'b10, 4'b0000);
        add("addi",       32'h00508193, 5'b00000, 7'b1100000, 3'b000, 2'b00, 4'b0000);
        add("srai",       32'h4030D193, 5'b00111, 7'b1100000, 3'b000, 2'b00, 4'b0000);
        add("slli_bad",   32'h02309193, 5'b00000, 7'b0000000, 3'b000, 2'b00, 4'b0001);
        add("opc_7f",     32'h0000007F, 5'b00000, 7'b0000000, 3'b000, 2'b00, 4'b0001);
        add("mret",       32'h30200073, 5'b00000, 7'b0000000, 3'b000, 2'b11, 4'b0010);
        add("csrrw",      32'h34029073, 5'b00000, 7'b1000000, 3'b000, 2'b11, 4'b0100);
        add("csrrs",      32'h340021F3, 5'b00000, 7'b1000000, 3'b000, 2'b11, 4'b1000);
        add("csrrsi",     32'h3401E1F3, 5'b00000, 7'b1000000, 3'b000, 2'b11, 4'b1000);
        add("r_f7_bad",   32'h042081B3, 5'b00000, 7'b0000000, 3'b000, 2'b00, 4'b0001);
        add("alt_f3_bad", 32'h402091B3, 5'b00000, 7'b0000000, 3'b000, 2'b00, 4'b0001);
        add("srli_bad",   32'h0430D193, 5'b00000, 7'b0000000, 3'b000, 2'b00, 4'b0001);

        // Back-to-back single-cycle decodes under continuous out_ready.
        for (int i = 0; i <= vecs.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                check({vecs[i-1].name, "_ovalid"}, 32'(out_valid), 32'd1);
                check(vecs[i-1].name, 32'(act), 32'(vecs[i-1].exp));
                check({vecs[i-1].name, "_inrdy"}, 32'(in_ready), 32'd1);
            end
            if (i < vecs.size()) begin
                instr    = vecs[i].ins;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("table_drained", 32'(out_valid), 32'd0);

        // Multi-cycle M ops
        run_m("mul", IMul, 5'b01011, MulLat);
        run_m("divu", IDivu, 5'b10001, DivLat);

        // Backpressure on SW for two cycles
        begin
            int x0;
            @(negedge clk);
            x0 = xfers; instr = ILw; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            check("bp_lw", 32'(act), 32'(ELw));
            instr = ISw;
            @(negedge clk);
            check("bp_sw", 32'(act), 32'(ESw));
            out_ready = 1'b0; instr = IBeq;
            #1 check("bp_inrdy_low", 32'(in_ready), 32'd0);
            for (int s = 1; s <= 2; s++) begin
                @(negedge clk);
                check($sformatf("bp_hold%0d", s), 32'(act), 32'(ESw));
                check($sformatf("bp_hold%0d_ovalid", s), 32'(out_valid), 32'd1);
                check($sformatf("bp_hold%0d_inrdy", s), 32'(in_ready), 32'd0);
            end
            out_ready = 1'b1;
            @(negedge clk);
            check("bp_beq", 32'(act), 32'(EBeq));
            check("bp_beq_ovalid", 32'(out_valid), 32'd1);
            in_valid = 1'b0;
            @(negedge clk);
            check("bp_drained", 32'(out_valid), 32'd0);
            check("bp_xfers", 32'(xfers - x0), 32'd3);
        end

        // Flush during DIV wait with a concurrent valid instruction
        begin
            int x0;
            @(negedge clk);
            x0 = xfers; instr = IDiv; in_valid = 1'b1;
            @(negedge clk);
            check("fl_div_busy", 32'(busy), 32'd1);
            in_valid = 1'b0;
            @(negedge clk);
            flush = 1'b1; in_valid = 1'b1; instr = IAdd;
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b0;
            check("fl_busy", 32'(busy), 32'd0);
            check("fl_inrdy", 32'(in_ready), 32'd1);
            for (int c = 0; c < int'(DivLat); c++) begin
                @(negedge clk);
                check($sformatf("fl_no_ovalid%0d", c), 32'(out_valid), 32'd0);
            end
            // flush also beats an accept in EMPTY
            instr = IAdd; in_valid = 1'b1; flush = 1'b1;
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b0;
            check("fl_vs_accept", 32'(out_valid), 32'd0);
            @(negedge clk);
            check("fl_xfers", 32'(xfers - x0), 32'd0);
        end

        // M encoding with EN_M_EXT=0 is a single-cycle illegal op
        @(negedge clk);
        instr = IMul; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        check("nom_ovalid", 32'(out_valid2), 32'd1);
        check("nom_bundle", 32'(act2), 32'(EIll));
        check("nom_busy", 32'(busy2), 32'd0);

        // Asynchronous reset in the middle of a DIV wait
        @(negedge clk);
        instr = IDiv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ar_loaded", 32'(aluop), 32'(5'b10000));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("ar_bundle", 32'(act), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_ovalid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("ar_inrdy", 32'(in_ready), 32'd1);
        instr = IAdd; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("ar_add_ovalid", 32'(out_valid), 32'd1);
        check("ar_add", 32'(act), 32'(EAdd));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
